regfile_writeback_arbiter: RTL and testbench

//  Write-side front end of the 16x32 register file. Accepts results from two producers, ALU and memory-load,

---
 rtl/regfile_writeback_arbiter.sv | 138 +++++++++++++
 tb/tb_regfile_writeback_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_arbiter.sv
// Write-side front end of the 16x32 register file: two source FIFOs (ALU, MEM), starvation-bounded
// arbitration, registered write port and per-register pending mask. Optional macro: WB_R0_ZERO_EN.
module regfile_writeback_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_vld,
  output logic        alu_rdy,
  input  logic [3:0]  alu_dst,
  input  logic [31:0] alu_data,
  input  logic        alu_high,
  input  logic        alu_low,
  input  logic        mem_vld,
  output logic        mem_rdy,
  input  logic [3:0]  mem_dst,
  input  logic [31:0] mem_data,
  output logic        wr,
  output logic [3:0]  wr_dst,
  output logic [31:0] wr_data,
  output logic        high,
  output logic        low,
  output logic [15:0] pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(2 * DEPTH + 2);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [3:0]  dst;
    logic [31:0] data;
    logic        high;
    logic        low;
  } wb_entry_t;

  wb_entry_t       alu_mem_q [DEPTH];
  wb_entry_t       mem_mem_q [DEPTH];
  logic [PW-1:0]   alu_wp_q, alu_rp_q, mem_wp_q, mem_rp_q;
  logic [SW-1:0]   starve_q, starve_d;
  logic [CW-1:0]   cnt_q [16];
  logic [CW-1:0]   cnt_d [16];
  logic [15:0]     pending_q, pending_d;
  wb_entry_t       out_q;
  logic            wr_q;

  logic alu_full, alu_empty, mem_full, mem_empty;
  logic alu_keep, mem_keep, alu_push, mem_push;
  logic mem_grant, alu_grant;
  wb_entry_t alu_head, mem_head;

  assign alu_full  = (alu_wp_q[AW] != alu_rp_q[AW]) && (alu_wp_q[AW-1:0] == alu_rp_q[AW-1:0]);
  assign mem_full  = (mem_wp_q[AW] != mem_rp_q[AW]) && (mem_wp_q[AW-1:0] == mem_rp_q[AW-1:0]);
  assign alu_empty = (alu_wp_q == alu_rp_q);
  assign mem_empty = (mem_wp_q == mem_rp_q);
  assign alu_rdy   = !alu_full;
  assign mem_rdy   = !mem_full;

`ifdef WB_R0_ZERO_EN
  // r0 is hardwired: the handshake completes but the entry is discarded.
  assign alu_keep = (alu_dst != 4'd0);
  assign mem_keep = (mem_dst != 4'd0);
`else
  assign alu_keep = 1'b1;
  assign mem_keep = 1'b1;
`endif

  assign alu_push  = alu_vld && alu_rdy && alu_keep;
  assign mem_push  = mem_vld && mem_rdy && mem_keep;
  assign alu_head  = alu_mem_q[alu_rp_q[AW-1:0]];
  assign mem_head  = mem_mem_q[mem_rp_q[AW-1:0]];
  assign mem_grant = !mem_empty && (alu_empty || (starve_q < SW'(STARVE_MAX)));
  assign alu_grant = !mem_grant && !alu_empty;

  // NOTE: FIFO storage has no reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (alu_push)
      alu_mem_q[alu_wp_q[AW-1:0]] <= '{dst: alu_dst, data: alu_data, high: alu_high,
                                       low: alu_low && !alu_high};
    if (mem_push)
      mem_mem_q[mem_wp_q[AW-1:0]] <= '{dst: mem_dst, data: mem_data, high: 1'b0, low: 1'b0};
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    starve_d = starve_q;
    if (mem_grant)
      starve_d = alu_empty ? '0 : starve_q + SW'(1);
    else if (alu_grant)
      starve_d = '0;
  end

  always_comb begin
    for (int r = 0; r < 16; r++) begin
      cnt_d[r] = cnt_q[r];
      if (alu_push && (alu_dst == 4'(r))) cnt_d[r] = cnt_d[r] + CW'(1);
      if (mem_push && (mem_dst == 4'(r))) cnt_d[r] = cnt_d[r] + CW'(1);
      if (wr_q && (out_q.dst == 4'(r)))   cnt_d[r] = cnt_d[r] - CW'(1);
      pending_d[r] = (cnt_d[r] != '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_wp_q  <= '0;
      alu_rp_q  <= '0;
      mem_wp_q  <= '0;
      mem_rp_q  <= '0;
      starve_q  <= '0;
      pending_q <= '0;
      wr_q      <= 1'b0;
      out_q     <= '0;
      for (int r = 0; r < 16; r++) cnt_q[r] <= '0;
    end else begin
      if (alu_push)  alu_wp_q <= alu_wp_q + PW'(1);
      if (mem_push)  mem_wp_q <= mem_wp_q + PW'(1);
      if (alu_grant) alu_rp_q <= alu_rp_q + PW'(1);
      if (mem_grant) mem_rp_q <= mem_rp_q + PW'(1);
      starve_q  <= starve_d;
      pending_q <= pending_d;
      wr_q      <= mem_grant || alu_grant;
      if (mem_grant)      out_q <= mem_head;
      else if (alu_grant) out_q <= alu_head;
      for (int r = 0; r < 16; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  assign wr      = wr_q;
  assign wr_dst  = out_q.dst;
  assign wr_data = out_q.data;
  assign high    = out_q.high;
  assign low     = out_q.low;
  assign pending = pending_q;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter; a second instance with starvation forcing
// effectively disabled shares the inputs for the arbitration-order comparison.
module tb_regfile_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_vld, alu_high, alu_low, mem_vld;
  logic [3:0]  alu_dst, mem_dst;
  logic [31:0] alu_data, mem_data;

  logic        alu_rdy, mem_rdy, wr, high, low;
  logic [3:0]  wr_dst;
  logic [31:0] wr_data;
  logic [15:0] pending;

  logic        ns_alu_rdy, ns_mem_rdy, ns_wr, ns_high, ns_low;
  logic [3:0]  ns_wr_dst;
  logic [31:0] ns_wr_data;
  logic [15:0] ns_pending;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_writeback_arbiter #(.DEPTH(4), .STARVE_MAX(3)) u_dut (
    .clk(clk), .rst(rst),
    .alu_vld(alu_vld), .alu_rdy(alu_rdy), .alu_dst(alu_dst), .alu_data(alu_data),
    .alu_high(alu_high), .alu_low(alu_low),
    .mem_vld(mem_vld), .mem_rdy(mem_rdy), .mem_dst(mem_dst), .mem_data(mem_data),
    .wr(wr), .wr_dst(wr_dst), .wr_data(wr_data), .high(high), .low(low), .pending(pending)
  );

  regfile_writeback_arbiter #(.DEPTH(4), .STARVE_MAX(64)) u_dut_ns (
    .clk(clk), .rst(rst),
    .alu_vld(alu_vld), .alu_rdy(ns_alu_rdy), .alu_dst(alu_dst), .alu_data(alu_data),
    .alu_high(alu_high), .alu_low(alu_low),
    .mem_vld(mem_vld), .mem_rdy(ns_mem_rdy), .mem_dst(mem_dst), .mem_data(mem_data),
    .wr(ns_wr), .wr_dst(ns_wr_dst), .wr_data(ns_wr_data), .high(ns_high), .low(ns_low),
    .pending(ns_pending)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_vld = 1'b0; alu_dst = '0; alu_data = '0; alu_high = 1'b0; alu_low = 1'b0;
    mem_vld = 1'b0; mem_dst = '0; mem_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_m [7];
    int exp_n [7];
    exp_m = '{8, 9, 10, 1, 11, 12, 13};
    exp_n = '{8, 9, 10, 11, 12, 13, 1};

    // ---- reset state ----
    idle_inputs();
    rst = 1'b1;
    tick();
    check("rst_wr",      wr, 0);
    check("rst_wr_dst",  wr_dst, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_high",    high, 0);
    check("rst_low",     low, 0);
    check("rst_pending", pending, 0);
    check("rst_alu_rdy", alu_rdy, 1);
    check("rst_mem_rdy", mem_rdy, 1);
    rst = 1'b0;
    tick();

    // ---- 1: single ALU write, latency 2, pending window ----
    do_reset();
    alu_vld = 1'b1; alu_dst = 4'd5; alu_data = 32'h1234_5678;
    check("t1_c0_wr", wr, 0);
    tick();
    alu_vld = 1'b0;
    check("t1_c1_wr", wr, 0);
    check("t1_c1_pending", pending, 32'h0020);
    tick();
    check("t1_c2_wr", wr, 1);
    check("t1_c2_dst", wr_dst, 5);
    check("t1_c2_data", wr_data, 32'h1234_5678);
    check("t1_c2_pending", pending, 32'h0020);
    tick();
    check("t1_c3_wr", wr, 0);
    check("t1_c3_pending", pending, 0);
    check("t1_c3_dst_hold", wr_dst, 5);

    // ---- 2: starvation bound M,M,M,A,M vs no forcing ----
    do_reset();
    alu_vld = 1'b1; alu_dst = 4'd1; alu_data = 32'hA1;
    mem_vld = 1'b1; mem_dst = 4'd8; mem_data = 32'h80;
    for (int c = 1; c <= 9; c++) begin
      tick();
      alu_vld  = 1'b0;
      mem_vld  = (c <= 5);
      mem_dst  = 4'(8 + c);
      mem_data = 32'h80 + 32'(c);
      if (c == 1) check("t2_c1_pending", pending, 32'h0102);
      if (c >= 2 && c <= 8) begin
        check($sformatf("t2_c%0d_wr", c), wr, 1);
        check($sformatf("t2_c%0d_dst", c), wr_dst, 32'(exp_m[c-2]));
        check($sformatf("t2ns_c%0d_wr", c), ns_wr, 1);
        check($sformatf("t2ns_c%0d_dst", c), ns_wr_dst, 32'(exp_n[c-2]));
      end else begin
        check($sformatf("t2_c%0d_idle", c), wr, 0);
        check($sformatf("t2ns_c%0d_idle", c), ns_wr, 0);
      end
    end
    check("t2_alu_data", wr_data, 32'h85);

    // ---- 3: fill ALU FIFO while MEM is granted, full-and-pop, FIFO order ----
    do_reset();
    alu_vld = 1'b1; alu_dst = 4'd2; alu_data = 32'hA0;
    mem_vld = 1'b1; mem_dst = 4'd12; mem_data = 32'hC0;
    tick();
    check("t3_c1_alu_rdy", alu_rdy, 1);
    alu_dst = 4'd3; alu_data = 32'hA1; mem_dst = 4'd13; mem_data = 32'hC1;
    tick();
    check("t3_c2_dst", wr_dst, 12);
    alu_dst = 4'd4; alu_data = 32'hA2; mem_dst = 4'd14; mem_data = 32'hC2;
    tick();
    check("t3_c3_dst", wr_dst, 13);
    alu_dst = 4'd5; alu_data = 32'hA3; mem_vld = 1'b0;
    tick();
    check("t3_c4_alu_rdy_full", alu_rdy, 0);
    check("t3_c4_dst", wr_dst, 14);
    check("t3_c4_pending", pending, 32'h403C);
    alu_dst = 4'd6; alu_data = 32'hA4;
    tick();
    check("t3_c5_alu_rdy", alu_rdy, 1);
    check("t3_c5_wr", wr, 1);
    check("t3_c5_dst", wr_dst, 2);
    tick();
    alu_vld = 1'b0;
    check("t3_c6_dst", wr_dst, 3);
    tick();
    check("t3_c7_dst", wr_dst, 4);
    tick();
    check("t3_c8_dst", wr_dst, 5);
    tick();
    check("t3_c9_dst", wr_dst, 6);
    check("t3_c9_data", wr_data, 32'hA4);
    tick();
    check("t3_c10_wr", wr, 0);
    check("t3_c10_pending", pending, 0);

    // ---- 4: half-write normalisation ----
    do_reset();
    alu_vld = 1'b1; alu_dst = 4'd7; alu_data = 32'h0000_ABCD; alu_high = 1'b1; alu_low = 1'b1;
    tick();
    alu_vld = 1'b0; alu_high = 1'b0; alu_low = 1'b0;
    mem_vld = 1'b1; mem_dst = 4'd9; mem_data = 32'hDEAD_BEEF;
    tick();
    mem_vld = 1'b0;
    check("t4_alu_dst", wr_dst, 7);
    check("t4_alu_data", wr_data, 32'h0000_ABCD);
    check("t4_alu_high", high, 1);
    check("t4_alu_low", low, 0);
    alu_vld = 1'b1; alu_dst = 4'd10; alu_data = 32'h5555; alu_low = 1'b1;
    tick();
    alu_vld = 1'b0; alu_low = 1'b0;
    check("t4_mem_dst", wr_dst, 9);
    check("t4_mem_data", wr_data, 32'hDEAD_BEEF);
    check("t4_mem_high", high, 0);
    check("t4_mem_low", low, 0);
    tick();
    check("t4_lo_only_high", high, 0);
    check("t4_lo_only_low", low, 1);
    tick();
    check("t4_hold_wr", wr, 0);
    check("t4_hold_dst", wr_dst, 10);
    check("t4_hold_low", low, 1);

    // ---- 5: reset with entries queued ----
    do_reset();
    alu_vld = 1'b1; alu_dst = 4'd2; mem_vld = 1'b1; mem_dst = 4'd3;
    tick();
    alu_dst = 4'd4; mem_dst = 4'd5;
    tick();
    idle_inputs();
    check("t5_pre_wr_dst", wr_dst, 3);
    check("t5_pre_pending", pending, 32'h003C);
    rst = 1'b1;
    #1;
    check("t5_async_wr", wr, 0);
    check("t5_async_pending", pending, 0);
    tick();
    check("t5_rst_wr", wr, 0);
    check("t5_rst_pending", pending, 0);
    check("t5_rst_alu_rdy", alu_rdy, 1);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("t5_post%0d_wr", c), wr, 0);
      check($sformatf("t5_post%0d_pending", c), pending, 0);
    end

    // ---- 6: r0 handling ----
    do_reset();
    alu_vld = 1'b1; alu_dst = 4'd0; alu_data = 32'h0BAD;
    tick();
    alu_vld = 1'b0;
    check("t6_alu_rdy", alu_rdy, 1);
`ifdef WB_R0_ZERO_EN
    check("t6_pending0", pending, 0);
    tick();
    check("t6_no_wr", wr, 0);
    tick();
    check("t6_no_wr_late", wr, 0);
    check("t6_pending_late", pending, 0);
`else
    check("t6_pending0", pending, 32'h0001);
    tick();
    check("t6_wr", wr, 1);
    check("t6_wr_dst", wr_dst, 0);
    check("t6_wr_data", wr_data, 32'h0BAD);
    tick();
    check("t6_wr_done", wr, 0);
    check("t6_pending_late", pending, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
